// File: rtl/imm_pkg.sv
// Shared immediate-field layout for the encoder and the sign-extender stage.
// Format codes, field positions/widths, FSM states and small decode helpers.
package imm_pkg;

   localparam int unsigned IMM_WIDTH     = 64;
   localparam int unsigned FIELD_W       = 26;
   localparam int unsigned CHUNK_W       = 16;
   localparam int unsigned NUM_CHUNKS    = 4;

   localparam int unsigned I_LSB         = 10;
   localparam int unsigned I_W           = 12;
   localparam int unsigned D_LSB         = 12;
   localparam int unsigned D_W           = 9;
   localparam int unsigned B_LSB         = 0;
   localparam int unsigned B_W           = 26;
   localparam int unsigned CB_LSB        = 5;
   localparam int unsigned CB_W          = 19;
   localparam int unsigned MOV_HW_LSB    = 21;
   localparam int unsigned MOV_CHUNK_LSB = 5;

   typedef enum logic [2:0] {
      FMT_I   = 3'b000,
      FMT_D   = 3'b001,
      FMT_B   = 3'b010,
      FMT_CB  = 3'b011,
      FMT_MOV = 3'b100
   } fmt_e;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_e;

   // Any code with bit 2 set is a wide move; the low bits are don't-care there.
   function automatic fmt_e decode_fmt(input logic [2:0] ctrl);
      return ctrl[2] ? FMT_MOV : fmt_e'(ctrl);
   endfunction

   // True when v is exactly the sign extension of its low n bits.
   function automatic logic fits_signed(input logic [IMM_WIDTH-1:0] v, input int unsigned n);
      logic [IMM_WIDTH-1:0] s;
      s = IMM_WIDTH'($signed(v) >>> (n - 1));
      return (&s) || (~|s);
   endfunction

endpackage

// File: rtl/imm_field_encoder_if.sv
// Request/beat bus between constant generation, the encoder and the imem writer.
interface imm_field_encoder_if;
   import imm_pkg::*;

   logic                 InValid;
   logic                 InReady;
   logic [IMM_WIDTH-1:0] BusImm;
   logic [2:0]           Ctrl;
   logic                 OutValid;
   logic                 OutReady;
   logic [FIELD_W-1:0]   Imm26;
   logic                 OutFirst;
   logic                 OutLast;
   logic                 OutErr;

   modport master (
      output InValid, BusImm, Ctrl, OutReady,
      input  InReady, OutValid, Imm26, OutFirst, OutLast, OutErr
   );

   modport slave (
      input  InValid, BusImm, Ctrl, OutReady,
      output InReady, OutValid, Imm26, OutFirst, OutLast, OutErr
   );

endinterface

// File: rtl/imm_chunk_select.sv
// Lowest-set-bit priority encoder over the wide-move chunk mask.
module imm_chunk_select
   import imm_pkg::*;
(
   input  logic [NUM_CHUNKS-1:0] mask,
   output logic [1:0]            idx,
   output logic                  found,
   output logic [NUM_CHUNKS-1:0] rest
);

   always_comb begin
      idx   = 2'd0;
      found = 1'b0;
      for (int k = NUM_CHUNKS - 1; k >= 0; k--) begin
         if (mask[k]) begin
            idx   = 2'(k);
            found = 1'b1;
         end
      end
      rest = mask & NUM_CHUNKS'(mask - NUM_CHUNKS'(1));
   end

endmodule

// File: rtl/imm_field_encoder.sv
// Packs a 64-bit immediate into the 26-bit instruction field, splitting
// wide moves into a MOVZ/MOVK beat sequence.
module imm_field_encoder
   import imm_pkg::*;
#(
   parameter bit          SKIP_ZERO = 1'b1,
   parameter int unsigned IMM_W     = IMM_WIDTH
) (
   input  logic                Clk,
   input  logic                Reset,
   imm_field_encoder_if.slave  bus
);

   state_e               state_q, state_d;
   logic [IMM_W-1:0]     imm_q, imm_d;
   logic [NUM_CHUNKS-1:0] mask_q, mask_d;
   logic                 in_ready_q, in_ready_d;
   logic                 out_valid_q, out_valid_d;
   logic [FIELD_W-1:0]   imm26_q, imm26_d;
   logic                 first_q, first_d;
   logic                 last_q, last_d;
   logic                 err_q, err_d;

   logic [IMM_WIDTH-1:0]  src_imm_c;
   logic [NUM_CHUNKS-1:0] new_mask_c, sel_mask_c, rest_c;
   logic [1:0]            sel_idx_c, hw_c;
   logic                  found_c;
   logic [CHUNK_W-1:0]    chunk_c;
   logic [FIELD_W-1:0]    mov_field_c;

   // In IDLE the first beat is built straight from the bus; afterwards from latched copies.
   always_comb begin
      src_imm_c = (state_q == IDLE) ? bus.BusImm : IMM_WIDTH'(imm_q);
      for (int k = 0; k < NUM_CHUNKS; k++) begin
         new_mask_c[k] = (bus.BusImm[k*CHUNK_W +: CHUNK_W] != '0) || !SKIP_ZERO;
      end
      sel_mask_c  = (state_q == IDLE) ? new_mask_c : mask_q;
      hw_c        = found_c ? sel_idx_c : 2'd0;
      chunk_c     = src_imm_c[{hw_c, 4'b0000} +: CHUNK_W];
      mov_field_c = (FIELD_W'(hw_c) << MOV_HW_LSB) | (FIELD_W'(chunk_c) << MOV_CHUNK_LSB);
   end

   imm_chunk_select u_chunk_select (
      .mask  (sel_mask_c),
      .idx   (sel_idx_c),
      .found (found_c),
      .rest  (rest_c)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= IDLE;
         imm_q       <= '0;
         mask_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         imm26_q     <= '0;
         first_q     <= 1'b0;
         last_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         imm_q       <= imm_d;
         mask_q      <= mask_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         imm26_q     <= imm26_d;
         first_q     <= first_d;
         last_q      <= last_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      imm_d       = imm_q;
      mask_d      = mask_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      imm26_d     = imm26_q;
      first_d     = first_q;
      last_d      = last_q;
      err_d       = err_q;

      case (state_q)
         IDLE: begin
            if (bus.InValid && in_ready_q) begin
               state_d     = EMIT;
               imm_d       = IMM_W'(bus.BusImm);
               in_ready_d  = 1'b0;
               out_valid_d = 1'b1;
               first_d     = 1'b1;
               last_d      = 1'b1;
               mask_d      = '0;
               case (decode_fmt(bus.Ctrl))
                  FMT_I: begin
                     imm26_d = FIELD_W'(bus.BusImm[I_W-1:0]) << I_LSB;
                     err_d   = !fits_signed(bus.BusImm, I_W);
                  end
                  FMT_D: begin
                     imm26_d = FIELD_W'(bus.BusImm[D_W-1:0]) << D_LSB;
                     err_d   = !fits_signed(bus.BusImm, D_W);
                  end
                  FMT_B: begin
                     imm26_d = FIELD_W'(bus.BusImm[B_W-1:0]) << B_LSB;
                     err_d   = !fits_signed(bus.BusImm, B_W);
                  end
                  FMT_CB: begin
                     imm26_d = FIELD_W'(bus.BusImm[CB_W-1:0]) << CB_LSB;
                     err_d   = !fits_signed(bus.BusImm, CB_W);
                  end
                  default: begin
                     imm26_d = mov_field_c;
                     err_d   = 1'b0;
                     last_d  = (rest_c == '0);
                     mask_d  = rest_c;
                  end
               endcase
            end
         end
         EMIT: begin
            if (out_valid_q && bus.OutReady) begin
               if (last_q) begin
                  state_d     = IDLE;
                  in_ready_d  = 1'b1;
                  out_valid_d = 1'b0;
                  imm26_d     = '0;
                  first_d     = 1'b0;
                  last_d      = 1'b0;
                  err_d       = 1'b0;
               end else begin
                  imm26_d = mov_field_c;
                  first_d = 1'b0;
                  last_d  = (rest_c == '0);
                  err_d   = 1'b0;
                  mask_d  = rest_c;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.InReady  = in_ready_q;
   assign bus.OutValid = out_valid_q;
   assign bus.Imm26    = imm26_q;
   assign bus.OutFirst = first_q;
   assign bus.OutLast  = last_q;
   assign bus.OutErr   = err_q;

endmodule
